// File: rtl/posit_mul_sequencer.sv
// Posit32 operand queue + issue sequencer for the multiplier core (optional POSIT_SEQ_BYPASS_EN zero/NaR shortcut).
// Result valid core_latency+1 cycles after the start pulse; in_ready = FIFO not full, results held until out_ready.
module posit_mul_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             core_start,
  output logic [31:0]      core_a,
  output logic [31:0]      core_b,
  input  logic [31:0]      core_result,
  input  logic             core_done
);

  localparam int          PTR_W    = $clog2(DEPTH);
  localparam logic [31:0] NAR      = 32'h8000_0000;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t             state, state_nxt;
  logic [31:0]        mem_a   [DEPTH];
  logic [31:0]        mem_b   [DEPTH];
  logic [TAG_W-1:0]   mem_tag [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic [15:0]        tmo_cnt;
  logic               push, pop, timed_out, bypass;
  logic [31:0]        bypass_res;

  // count never exceeds DEPTH (a power of two), so its MSB alone flags full
  assign in_ready  = ~count[PTR_W];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign core_a    = mem_a[rd_ptr];
  assign core_b    = mem_b[rd_ptr];
  assign timed_out = (tmo_cnt == TMO_LAST);

`ifdef POSIT_SEQ_BYPASS_EN
  assign bypass     = (count != '0) &&
                      (core_a == 32'h0 || core_a == NAR || core_b == 32'h0 || core_b == NAR);
  assign bypass_res = (core_a == NAR || core_b == NAR) ? NAR : 32'h0;
`else
  assign bypass     = 1'b0;
  assign bypass_res = 32'h0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bypass) state_nxt = HOLD;
               else if (count != '0) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (core_done || timed_out) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_start = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ISSUE:   core_start = 1'b1;
      HOLD:    out_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt    <= '0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else begin
      if (state == ISSUE) tmo_cnt <= '0;
      else if (state == WAIT && !core_done && !timed_out) tmo_cnt <= tmo_cnt + 1'b1;

      if (state == IDLE && bypass) begin
        out_result <= bypass_res;
        out_tag    <= mem_tag[rd_ptr];
        out_err    <= 1'b0;
      end else if (state == WAIT && core_done) begin
        out_result <= core_result;
        out_tag    <= mem_tag[rd_ptr];
        out_err    <= 1'b0;
      end else if (state == WAIT && timed_out) begin
        out_result <= NAR;
        out_tag    <= mem_tag[rd_ptr];
        out_err    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

endmodule
